spi_master_ctrl: RTL and testbench
==================================

Name: spi_master_ctrl

Overview:
Hardware SPI master (mode 0, MSB first) that sequences byte transfers on the board SPI pins. It drives up to three chip selects and holds a select across multi-byte frames. It replaces bit-banged soft SPI and sits between a CPU register/PIO port and the spi_MISO/MOSI/SCLK/SS_n pins. One byte per start/busy handshake; the caller marks the final byte of a frame.

Parameters:
CLK_DIV, 4, sys_clk cycles per SCLK half-period; legal range 1..255; SCLK = f(sys_clk)/(2*CLK_DIV)
NUM_SS, 3, number of chip-select outputs; legal range 1..4

Ports:
sys_clk  input  1  system clock; all logic on the rising edge
sys_rst_n  input  1  asynchronous active-low reset
start  input  1  request one byte transfer; accepted only in a cycle where busy=0
ss_sel  input  2  chip-select index, latched at an accepted start when no select is held; value >= NUM_SS means no select asserted
tx_data  input  8  byte to send, latched at an accepted start
last  input  1  latched at an accepted start; 1 = deassert the select after this byte
cs_release  input  1  when idle with a select held: deassert it without a transfer
busy  output  1  transfer, hold or deassert in progress; start is ignored while 1
rx_data  output  8  last received byte; stable until the next rx_valid
rx_valid  output  1  one-cycle pulse when rx_data is updated
spi_SCLK  output  1  SPI clock; idle low
spi_MOSI  output  1  SPI data out
spi_MISO  input  1  SPI data in
spi_SS_n  output  NUM_SS  active-low selects; at most one low

Behaviour:
- Reset (async assert): outputs go to spi_SS_n all 1, spi_SCLK 0, spi_MOSI 0, busy 0, rx_valid 0, rx_data 0x00. State goes to IDLE and the held-select flag clears. Reset asserted mid-transfer aborts the transfer immediately with no rx_valid.
- States are IDLE, SHIFT, HOLD and DESEL. One phase counter counts 0..CLK_DIV-1. One bit counter counts 0..7.
- IDLE plus start in cycle 0:
  - tx_data, last and ss_sel are latched. ss_sel is latched only if no select is held; otherwise the held select is reused.
  - In cycle 1: state SHIFT, busy 1, the selected spi_SS_n bit goes low (or stays low), spi_MOSI = tx_data[7], spi_SCLK 0.
- SHIFT: each bit has a low phase of CLK_DIV cycles followed by a high phase of CLK_DIV cycles.
  - The first low phase is the SS-to-SCLK setup time.
  - At the edge that drives spi_SCLK 1, spi_MISO is shifted into the receive register.
  - At the edge that drives spi_SCLK 0 (bits 0..6), spi_MOSI takes the next tx bit.
  - After the 8th high phase, spi_SCLK returns to 0. In that same cycle (cycle 16*CLK_DIV+1), rx_valid=1 and rx_data = received byte, MSB first.
- End of a byte with last=0: state IDLE and busy 0 in the rx_valid cycle. The select stays low and the held flag sets. spi_MOSI holds its final bit value.
- End of a byte with last=1: state HOLD for CLK_DIV cycles (SCLK low, SS low, busy 1). Then DESEL: SS_n goes all 1 and busy stays 1 for CLK_DIV cycles (minimum deselect time). Then IDLE with busy 0. Worked example: CLK_DIV=2 gives rx_valid at cycle 33, SS high at cycle 35, busy 0 at cycle 37.
- cs_release in IDLE with a select held: DESEL is entered next cycle, then the same timing as above. cs_release with no select held, or while busy, is ignored.
- start and cs_release together in IDLE: start wins and cs_release is ignored.
- start while busy=1 is ignored, with no queueing. tx_data, ss_sel and last changes while busy have no effect.
- ss_sel out of range: the transfer runs normally with all SS_n high.

Test Plan:
- Reset, then CLK_DIV=2, ss_sel=0, tx_data=0xA5, last=1, with spi_MISO looped to spi_MOSI → SS_n=3'b110 from cycle 1; 8 SCLK rising edges; MOSI bits 1,0,1,0,0,1,0,1; rx_valid in cycle 33 with rx_data=0xA5; SS_n=3'b111 at cycle 35; busy 0 at cycle 37.
- Three-byte frame (0x03, 0x00, 0xFF) on ss_sel=2, last=0,0,1, each start issued the cycle busy drops → SS_n[2] low continuously, no glitch between bytes; three rx_valid pulses; SS_n high only after the third byte.
- Frame with last=0 on ss_sel=1, then a start with ss_sel=0 → second byte still uses SS_n[1]; then cs_release → SS_n=3'b111 one cycle later and busy for CLK_DIV cycles.
- spi_MISO tied to 1 and start with tx_data=0x00 → rx_data=0xFF and MOSI constant 0; a start pulsed mid-transfer → ignored, exactly one rx_valid.
- Reset asserted at cycle 10 of a transfer → SS_n=3'b111, SCLK=0, busy=0 asynchronously; no rx_valid; rx_data=0x00.
- CLK_DIV=1 and ss_sel=3 → SCLK toggles every cycle; all SS_n stay high; rx_valid at cycle 17.

Source files
------------

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master, MSB first, one byte per start handshake, up to NUM_SS chip selects held across frames.
// Latency: rx_valid 16*CLK_DIV+1 cycles after the accepting edge; a last byte adds 2*CLK_DIV cycles before idle.
// Backpressure: start/cs_release are only honoured while busy=0; nothing is queued.
module spi_master_ctrl #(
    parameter int CLK_DIV = 4,
    parameter int NUM_SS  = 3
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              start,
    input  logic [1:0]        ss_sel,
    input  logic [7:0]        tx_data,
    input  logic              last,
    input  logic              cs_release,
    output logic              busy,
    output logic [7:0]        rx_data,
    output logic              rx_valid,
    output logic              spi_SCLK,
    output logic              spi_MOSI,
    input  logic              spi_MISO,
    output logic [NUM_SS-1:0] spi_SS_n
);
    typedef enum logic [1:0] {IDLE, SHIFT, HOLD, DESEL} state_t;

    localparam logic [7:0] PH_MAX = 8'(CLK_DIV - 1);

    state_t     state_q, state_d;
    logic [7:0] phase_q;
    logic [2:0] bit_q;
    logic [7:0] tx_sh_q;
    logic [7:0] rx_sh_q;
    logic [1:0] ss_idx_q;
    logic       last_q;
    logic       held_q;

    logic phase_end;
    logic accept;
    logic sclk_rise;
    logic sclk_fall;
    logic byte_done;

    assign phase_end = (phase_q == PH_MAX);
    assign busy      = (state_q != IDLE);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        sclk_rise = 1'b0;
        sclk_fall = 1'b0;
        byte_done = 1'b0;
        case (state_q)
            IDLE: begin
                // start takes priority over a simultaneous release
                if (start) begin
                    accept  = 1'b1;
                    state_d = SHIFT;
                end else if (cs_release && held_q) begin
                    state_d = DESEL;
                end
            end
            SHIFT: begin
                if (phase_end) begin
                    if (!spi_SCLK) begin
                        sclk_rise = 1'b1;
                    end else begin
                        sclk_fall = 1'b1;
                        if (bit_q == 3'd7) begin
                            byte_done = 1'b1;
                            state_d   = last_q ? HOLD : IDLE;
                        end
                    end
                end
            end
            HOLD: begin
                if (phase_end) state_d = DESEL;
            end
            DESEL: begin
                if (phase_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            phase_q  <= '0;
            bit_q    <= '0;
            tx_sh_q  <= '0;
            rx_sh_q  <= '0;
            ss_idx_q <= '0;
            last_q   <= 1'b0;
            held_q   <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            spi_SCLK <= 1'b0;
            spi_MOSI <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (state_q == IDLE || phase_end) phase_q <= '0;
            else                              phase_q <= phase_q + 8'd1;

            if (accept) begin
                tx_sh_q  <= tx_data;
                spi_MOSI <= tx_data[7];
                last_q   <= last;
                bit_q    <= '0;
                // a held select keeps its index for the rest of the frame
                if (!held_q) ss_idx_q <= ss_sel;
            end

            if (sclk_rise) begin
                spi_SCLK <= 1'b1;
                rx_sh_q  <= {rx_sh_q[6:0], spi_MISO};
            end

            if (sclk_fall) begin
                spi_SCLK <= 1'b0;
                if (byte_done) begin
                    rx_data  <= rx_sh_q;
                    rx_valid <= 1'b1;
                    if (!last_q) held_q <= 1'b1;
                end else begin
                    bit_q    <= bit_q + 3'd1;
                    tx_sh_q  <= {tx_sh_q[6:0], 1'b0};
                    spi_MOSI <= tx_sh_q[6];
                end
            end

            if (state_d == DESEL && state_q != DESEL) held_q <= 1'b0;
        end
    end

    always_comb begin
        spi_SS_n = '1;
        if (state_q == SHIFT || state_q == HOLD || (state_q == IDLE && held_q)) begin
            for (int i = 0; i < NUM_SS; i++) begin
                if (int'(ss_idx_q) == i) spi_SS_n[i] = 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_spi_master_ctrl.sv
// Testbench for spi_master_ctrl: two instances (CLK_DIV=2 and CLK_DIV=1) share stimulus;
// expected pin waveforms are computed per cycle from the SPI timing formulas.
module tb_spi_master_ctrl;
    logic       clk;
    logic       rst_n;
    logic       start;
    logic [1:0] ss_sel;
    logic [7:0] tx_data;
    logic       last;
    logic       cs_release;
    logic       miso_drv;
    logic       loop_en;
    logic       use_d1;

    logic       a_busy, a_rxv, a_sclk, a_mosi;
    logic [7:0] a_rx;
    logic [2:0] a_ss;
    logic       b_busy, b_rxv, b_sclk, b_mosi;
    logic [7:0] b_rx;
    logic [2:0] b_ss;
    logic       a_miso, b_miso;

    logic [6:0] o_vec;
    logic [7:0] o_rx;
    logic       o_busy;

    int         checks;
    int         failures;
    int         div;
    logic       held;
    logic [1:0] m_idx;
    logic       m_mosi;

    typedef struct {
        logic [7:0] tx;
        logic [1:0] sel;
        logic       lst;
        logic       lp;
        logic       rel;
        logic [7:0] rxp;
        logic       noise;
        logic       post_rel;
    } vec_t;

    vec_t tbl[6];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign a_miso = loop_en ? a_mosi : miso_drv;
    assign b_miso = loop_en ? b_mosi : miso_drv;

    spi_master_ctrl #(.CLK_DIV(2), .NUM_SS(3)) dut (
        .sys_clk(clk), .sys_rst_n(rst_n), .start(start), .ss_sel(ss_sel),
        .tx_data(tx_data), .last(last), .cs_release(cs_release), .busy(a_busy),
        .rx_data(a_rx), .rx_valid(a_rxv), .spi_SCLK(a_sclk), .spi_MOSI(a_mosi),
        .spi_MISO(a_miso), .spi_SS_n(a_ss)
    );

    spi_master_ctrl #(.CLK_DIV(1), .NUM_SS(3)) dut_d1 (
        .sys_clk(clk), .sys_rst_n(rst_n), .start(start), .ss_sel(ss_sel),
        .tx_data(tx_data), .last(last), .cs_release(cs_release), .busy(b_busy),
        .rx_data(b_rx), .rx_valid(b_rxv), .spi_SCLK(b_sclk), .spi_MOSI(b_mosi),
        .spi_MISO(b_miso), .spi_SS_n(b_ss)
    );

    assign o_vec  = use_d1 ? {b_ss, b_sclk, b_mosi, b_busy, b_rxv} : {a_ss, a_sclk, a_mosi, a_busy, a_rxv};
    assign o_rx   = use_d1 ? b_rx : a_rx;
    assign o_busy = use_d1 ? b_busy : a_busy;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h expected=%0h (vec = ss_n,sclk,mosi,busy,rx_valid)", nm, $time, act, exp);
        end
    endtask

    function automatic logic [2:0] ss_exp(input logic on);
        logic [2:0] v;
        v = 3'b111;
        if (on && m_idx < 2'd3) v[m_idx] = 1'b0;
        return v;
    endfunction

    // Entered anywhere inside the cycle that presents start; returns at the negedge of the rx_valid cycle.
    task automatic xfer(input logic [7:0] tx, input logic [1:0] sel, input logic lst, input logic lp,
                        input logic rel, input logic [7:0] rxp, input logic noise);
        logic [6:0] exp_v;
        logic [7:0] exp_rx;
        logic       sclk_e;
        int         k;
        chk("pre_start_busy", {15'b0, o_busy}, 16'd0);
        loop_en    = lp;
        start      = 1'b1;
        tx_data    = tx;
        ss_sel     = sel;
        last       = lst;
        cs_release = rel;
        if (!held) m_idx = sel;
        exp_rx = lp ? tx : rxp;
        @(posedge clk); #1;
        start      = 1'b0;
        cs_release = 1'b0;
        tx_data    = 8'($urandom);
        ss_sel     = 2'($urandom);
        last       = 1'($urandom);
        for (int c = 1; c <= 16*div + 1; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            k = (c - 1) / (2*div);
            if (c <= 16*div) begin
                miso_drv = rxp[3'(7 - k)];
                if (noise) begin
                    start      = 1'($urandom);
                    cs_release = 1'($urandom);
                end
            end else begin
                start      = 1'b0;
                cs_release = 1'b0;
            end
            @(negedge clk);
            if (c <= 16*div) begin
                sclk_e = (((c - 1) / div) % 2) == 1;
                exp_v  = {ss_exp(1'b1), sclk_e, tx[3'(7 - k)], 1'b1, 1'b0};
            end else begin
                exp_v  = {ss_exp(1'b1), 1'b0, tx[0], lst, 1'b1};
            end
            chk("xfer_cycle", {9'b0, o_vec}, {9'b0, exp_v});
        end
        chk("rx_data", {8'b0, o_rx}, {8'b0, exp_rx});
        held   = !lst;
        m_mosi = tx[0];
    endtask

    task automatic desel_tail();
        logic [6:0] e;
        for (int j = 1; j <= 2*div; j++) begin
            @(posedge clk); #1;
            @(negedge clk);
            e = {((j < div) ? ss_exp(1'b1) : 3'b111), 1'b0, m_mosi, 1'(j < 2*div), 1'b0};
            chk("desel_tail", {9'b0, o_vec}, {9'b0, e});
        end
        held = 1'b0;
    endtask

    task automatic release_seq();
        logic [6:0] e;
        cs_release = 1'b1;
        @(posedge clk); #1;
        cs_release = 1'b0;
        for (int r = 1; r <= div + 1; r++) begin
            if (r > 1) begin @(posedge clk); #1; end
            @(negedge clk);
            e = {3'b111, 1'b0, m_mosi, 1'(r <= div), 1'b0};
            chk("release_seq", {9'b0, o_vec}, {9'b0, e});
        end
        held = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("idle", {9'b0, o_vec}, {9'b0, ss_exp(held), 1'b0, m_mosi, 1'b0, 1'b0});
        end
    endtask

    task automatic run_vec(input vec_t v);
        xfer(v.tx, v.sel, v.lst, v.lp, v.rel, v.rxp, v.noise);
        if (v.lst)           desel_tail();
        else if (v.post_rel) release_seq();
    endtask

    task automatic hard_reset();
        rst_n = 1'b0;
        #1;
        chk("reset_vec", {9'b0, o_vec}, {9'b0, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0});
        chk("reset_rx", {8'b0, o_rx}, 16'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        held   = 1'b0;
        m_mosi = 1'b0;
    endtask

    initial begin
        vec_t rv;
        checks = 0; failures = 0;
        rst_n = 1'b0; start = 1'b0; ss_sel = 2'd0; tx_data = 8'd0; last = 1'b0;
        cs_release = 1'b0; miso_drv = 1'b0; loop_en = 1'b0; use_d1 = 1'b0;
        div = 2; held = 1'b0; m_idx = 2'd0; m_mosi = 1'b0;

        //          tx     sel   lst   lp    rel   rxp    noise post_rel
        tbl[0] = '{8'hA5, 2'd0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[1] = '{8'h03, 2'd2, 1'b0, 1'b0, 1'b0, 8'h96, 1'b0, 1'b0};
        tbl[2] = '{8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 8'h4E, 1'b0, 1'b0};
        tbl[3] = '{8'hFF, 2'd1, 1'b1, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0};
        tbl[4] = '{8'h00, 2'd1, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0};
        tbl[5] = '{8'h3C, 2'd0, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b1};

        #1;
        hard_reset();
        idle(2);
        for (int i = 0; i < 6; i++) run_vec(tbl[i]);

        // release with nothing held must be ignored
        cs_release = 1'b1;
        idle(1);
        cs_release = 1'b0;
        idle(1);

        for (int i = 0; i < 12; i++) begin
            rv.tx       = 8'($urandom);
            rv.sel      = 2'($urandom_range(0, 3));
            rv.lst      = 1'($urandom);
            rv.lp       = 1'($urandom);
            rv.rel      = 1'($urandom);
            rv.rxp      = 8'($urandom);
            rv.noise    = 1'b1;
            rv.post_rel = 1'($urandom);
            run_vec(rv);
        end
        if (held) release_seq();
        idle(1);

        // reset in cycle 10 of a transfer: aborts at once, no rx_valid
        start = 1'b1; tx_data = 8'h5A; ss_sel = 2'd0; last = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        hard_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_abort_rxv", {15'b0, o_vec[0]}, 16'd0);
        end
        idle(1);

        use_d1 = 1'b1;
        div    = 1;
        @(posedge clk); #1;
        hard_reset();
        idle(1);
        xfer(8'hC3, 2'd3, 1'b1, 1'b0, 1'b0, 8'($urandom), 1'b0);
        desel_tail();
        for (int i = 0; i < 4; i++) begin
            rv.tx       = 8'($urandom);
            rv.sel      = 2'($urandom_range(0, 3));
            rv.lst      = 1'($urandom);
            rv.lp       = 1'($urandom);
            rv.rel      = 1'b0;
            rv.rxp      = 8'($urandom);
            rv.noise    = 1'b1;
            rv.post_rel = 1'b1;
            run_vec(rv);
        end
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
